// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-limited instruction fetch with response FIFO and redirect flush
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] out_pcn,
    input  logic                  out_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      outstanding_next;
    logic [CNT_W-1:0]      drop;
    logic [CNT_W:0]        credit_used;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  unused_pc_bits;

    // Every in-flight request already owns a FIFO slot, so a kept response can always be pushed.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc;

    assign accept = imem_req_valid && imem_req_ready;
    assign push   = imem_rsp_valid && (drop == '0) && !redirect;
    assign pop    = out_valid && out_ready && !redirect;

    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    assign target_pc        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_pc_bits   = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                // Everything still in flight after this cycle belongs to the old stream.
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                wr_ptr   <= rd_ptr;
                count    <= '0;
                drop     <= outstanding_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                if (imem_rsp_valid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= RESET_PC;
            end
        end else if (push) begin
            mem_instr[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]    <= resp_pc;
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = mem_instr[rd_ptr];
    assign out_pc    = mem_pc[rd_ptr];
    assign out_pcn   = out_pc + ADDR_WIDTH'(4);
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with an in-order latency memory model
module tb_fetch_queue;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcn;
    logic        out_ready;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(4),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pcn(out_pcn),
        .out_ready(out_ready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    bit rand_lat = 1'b0;
    int last_due = -1;
    logic [31:0] mq_addr[$];
    int mq_due[$];
    logic [31:0] exp_pc;
    int got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory returns instruction = ~addr, in order, at least lat cycles after accept.
    task automatic step();
        int d;
        #1;
        if (imem_req_valid && imem_req_ready) begin
            d = cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(d);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq_addr[0];
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        out_ready = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        last_due = -1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        last_due = -1;
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, RPC);
        chk("rst_out_pcn", out_pcn, 32'h8000_0004);

        // Streaming, L=1
        do_reset();
        lat = 1; rand_lat = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t1_req_valid", imem_req_valid, 1'b1);
            chk("t1_req_addr", imem_req_addr, RPC + 32'(4 * c));
            if (c < 2) begin
                chk("t1_out_idle", out_valid, 1'b0);
            end else begin
                chk("t1_out_valid", out_valid, 1'b1);
                chk("t1_out_pc", out_pc, RPC + 32'(4 * (c - 2)));
                chk("t1_out_pcn", out_pcn, RPC + 32'(4 * (c - 1)));
                chk("t1_out_instr", out_instr, ~(RPC + 32'(4 * (c - 2))));
            end
            step();
        end

        // Credit limit with decode stalled
        do_reset();
        lat = 1; out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t2_req_valid", imem_req_valid, 1'b1);
            chk("t2_req_addr", imem_req_addr, RPC + 32'(4 * c));
            step();
        end
        #1; chk("t2_credit_stop_c4", imem_req_valid, 1'b0); step();
        #1;
        chk("t2_credit_stop_c5", imem_req_valid, 1'b0);
        chk("t2_full_valid", out_valid, 1'b1);
        chk("t2_head_pc", out_pc, RPC);
        step();
        out_ready = 1'b1;
        #1;
        chk("t2_no_comb_reissue", imem_req_valid, 1'b0);
        chk("t2_pop_pc", out_pc, RPC);
        step();
        out_ready = 1'b0;
        #1;
        chk("t2_reissue_valid", imem_req_valid, 1'b1);
        chk("t2_reissue_addr", imem_req_addr, 32'h8000_0010);
        chk("t2_next_head", out_pc, 32'h8000_0004);
        step();
        #1; chk("t2_refull_stop", imem_req_valid, 1'b0); step();

        // L=3, redirect while three are in flight (first response lands in the redirect cycle)
        do_reset();
        lat = 3; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; chk("t3_req_valid", imem_req_valid, 1'b1); step();
        end
        redirect = 1'b1; redirect_pc = 32'h8000_0100;
        #1; chk("t3_redirect_blocks", imem_req_valid, 1'b0); step();
        redirect = 1'b0;
        #1;
        chk("t3_target_valid", imem_req_valid, 1'b1);
        chk("t3_target_addr", imem_req_addr, 32'h8000_0100);
        chk("t3_no_stale_c4", out_valid, 1'b0);
        step();
        for (int c = 5; c < 8; c++) begin
            #1; chk("t3_no_stale", out_valid, 1'b0); step();
        end
        #1;
        chk("t3_first_valid", out_valid, 1'b1);
        chk("t3_first_pc", out_pc, 32'h8000_0100);
        chk("t3_first_instr", out_instr, 32'h7FFF_FEFF);
        chk("t3_credit_block", imem_req_valid, 1'b0);
        step();
        #1;
        chk("t3_second_pc", out_pc, 32'h8000_0104);
        chk("t3_reissue_addr", imem_req_addr, 32'h8000_0110);
        chk("t3_reissue_valid", imem_req_valid, 1'b1);
        step();
        #1; chk("t3_third_pc", out_pc, 32'h8000_0108); step();

        // Redirect while request is stalled; low target bits ignored
        do_reset();
        lat = 1; out_ready = 1'b1; imem_req_ready = 1'b0;
        #1;
        chk("t4_stalled_valid", imem_req_valid, 1'b1);
        chk("t4_stalled_addr", imem_req_addr, RPC);
        step();
        redirect = 1'b1; redirect_pc = 32'h8000_0043;
        #1; chk("t4_withdrawn", imem_req_valid, 1'b0); step();
        redirect = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("t4_new_valid", imem_req_valid, 1'b1);
        chk("t4_new_addr", imem_req_addr, 32'h8000_0040);
        chk("t4_idle_c2", out_valid, 1'b0);
        step();
        #1; chk("t4_idle_c3", out_valid, 1'b0); step();
        #1;
        chk("t4_out_valid", out_valid, 1'b1);
        chk("t4_out_pc", out_pc, 32'h8000_0040);
        chk("t4_out_pcn", out_pcn, 32'h8000_0044);
        step();

        // Back-to-back redirects with random latency
        do_reset();
        rand_lat = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        redirect = 1'b1; redirect_pc = 32'h8000_0200; step();
        redirect_pc = 32'h8000_0300; step();
        redirect = 1'b0;
        #1;
        chk("t5_flushed", out_valid, 1'b0);
        chk("t5_fetch_addr", imem_req_addr, 32'h8000_0300);
        step();
        #1; chk("t5_flushed_c8", out_valid, 1'b0); step();
        exp_pc = 32'h8000_0300;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (out_valid) begin
                chk("t5_stream_pc", out_pc, exp_pc);
                chk("t5_stream_instr", out_instr, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            step();
        end
        chk("t5_delivered_enough", 32'(got >= 8), 32'd1);
        rand_lat = 1'b0;

        // Reset with the FIFO full
        do_reset();
        lat = 1; out_ready = 1'b0;
        for (int c = 0; c < 6; c++) step();
        #1; chk("t6_full_before", out_valid, 1'b1);
        rst = 1'b1;
        mq_addr.delete(); mq_due.delete(); last_due = -1;
        #1; chk("t6_rst_req_valid", imem_req_valid, 1'b0);
        step();
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_out_instr", out_instr, 32'h0);
        chk("t6_out_pc", out_pc, RPC);
        chk("t6_out_pcn", out_pcn, 32'h8000_0004);
        chk("t6_req_addr", imem_req_addr, RPC);
        rst = 1'b0; cyc = 0; out_ready = 1'b1;
        #1;
        chk("t6_restart_valid", imem_req_valid, 1'b1);
        chk("t6_restart_addr", imem_req_addr, RPC);
        step();
        #1; chk("t6_second_addr", imem_req_addr, 32'h8000_0004); step();
        #1;
        chk("t6_first_out_valid", out_valid, 1'b1);
        chk("t6_first_out_pc", out_pc, RPC);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
